// File: rtl/segway_cmd_pkg.sv
// rtl/segway_cmd_pkg.sv - shared command bytes and state types for the Segway command link
package segway_cmd_pkg;

    localparam logic [7:0] GO_CMD   = 8'h47;
    localparam logic [7:0] STOP_CMD = 8'h53;

    typedef enum logic [1:0] {
        OFF,
        PWR1,
        PWR2
    } auth_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with RX synchronizer, framing check and baud/bit counters
module uart_rx_core
    import segway_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    localparam int                CNT_W    = $clog2(BAUD_DIV + 1);
    // Counts run down to 0 inclusive, so loading N-1 spans exactly N clocks.
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2 - 1);

    logic             r_sync1;
    logic             r_rx_s;
    logic             r_rx_d;
    rx_state_t        r_state;
    rx_state_t        w_nxt_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_nxt_baud_cnt;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_nxt_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       w_nxt_shift;
    logic [7:0]       r_rx_data;
    logic [7:0]       w_nxt_rx_data;
    logic             r_rx_rdy;
    logic             w_nxt_rx_rdy;
    logic             r_frm_err;
    logic             w_nxt_frm_err;
    logic             w_fall;
    logic             w_tick;

    assign w_fall = r_rx_d & ~r_rx_s;
    assign w_tick = (r_baud_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_d     <= 1'b1;
            r_state    <= RX_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_rdy   <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_sync1    <= RX;
            r_rx_s     <= r_sync1;
            r_rx_d     <= r_rx_s;
            r_state    <= w_nxt_state;
            r_baud_cnt <= w_nxt_baud_cnt;
            r_bit_cnt  <= w_nxt_bit_cnt;
            r_shift    <= w_nxt_shift;
            r_rx_data  <= w_nxt_rx_data;
            r_rx_rdy   <= w_nxt_rx_rdy;
            r_frm_err  <= w_nxt_frm_err;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_baud_cnt = r_baud_cnt;
        w_nxt_bit_cnt  = r_bit_cnt;
        w_nxt_shift    = r_shift;
        w_nxt_rx_data  = r_rx_data;
        w_nxt_rx_rdy   = 1'b0;
        w_nxt_frm_err  = 1'b0;
        if (r_state != RX_IDLE && !w_tick) begin
            w_nxt_baud_cnt = r_baud_cnt - 1'b1;
        end
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_nxt_state    = RX_START;
                    w_nxt_baud_cnt = HALF_BIT;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_nxt_state = RX_IDLE;
                    end else begin
                        w_nxt_state    = RX_DATA;
                        w_nxt_baud_cnt = FULL_BIT;
                        w_nxt_bit_cnt  = '0;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_nxt_shift    = {r_rx_s, r_shift[7:1]};
                    w_nxt_baud_cnt = FULL_BIT;
                    if (r_bit_cnt == 4'd7) begin
                        w_nxt_state   = RX_STOP;
                        w_nxt_bit_cnt = '0;
                    end else begin
                        w_nxt_bit_cnt = r_bit_cnt + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    w_nxt_state = RX_IDLE;
                    if (r_rx_s) begin
                        w_nxt_rx_data = r_shift;
                        w_nxt_rx_rdy  = 1'b1;
                    end else begin
                        w_nxt_frm_err = 1'b1;
                    end
                end
            end
            default: w_nxt_state = RX_IDLE;
        endcase
    end

    assign rx_data = r_rx_data;
    assign rx_rdy  = r_rx_rdy;
    assign frm_err = r_frm_err;

endmodule

// File: rtl/auth_cmd_receiver.sv
// rtl/auth_cmd_receiver.sv - BLE command receiver: UART RX plus power-up authorization FSM
module auth_cmd_receiver
    import segway_cmd_pkg::*;
#(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] GO_CMD   = segway_cmd_pkg::GO_CMD,
    parameter logic [7:0] STOP_CMD = segway_cmd_pkg::STOP_CMD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    auth_state_t r_auth;
    auth_state_t w_nxt_auth;
    logic        r_pwr_up;
    logic        w_go;
    logic        w_stop;

    uart_rx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (RX),
        .rx_data(rx_data),
        .rx_rdy (rx_rdy),
        .frm_err(frm_err)
    );

    assign w_go   = rx_rdy && (rx_data == GO_CMD);
    assign w_stop = rx_rdy && (rx_data == STOP_CMD);

    // PWR2 is "stop requested, waiting for the rider to step off"; a fresh GO re-authorizes.
    always_comb begin
        w_nxt_auth = r_auth;
        case (r_auth)
            OFF: begin
                if (w_go) w_nxt_auth = PWR1;
            end
            PWR1: begin
                if (w_stop) w_nxt_auth = rider_off ? OFF : PWR2;
            end
            PWR2: begin
                if (w_go)           w_nxt_auth = PWR1;
                else if (rider_off) w_nxt_auth = OFF;
            end
            default: w_nxt_auth = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auth   <= OFF;
            r_pwr_up <= 1'b0;
        end else begin
            r_auth   <= w_nxt_auth;
            r_pwr_up <= (w_nxt_auth != OFF);
        end
    end

    assign pwr_up = r_pwr_up;

endmodule
